core_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode stage and supplies its INST input.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready request channel.
- Buffers returned instructions, with their PCs, in a small FIFO.
- Presents one instruction per cycle to decode; discards stale responses after a redirect (branch, jump, trap, IRET).

---
 rtl/core_pkg.sv | 18 +
 rtl/core_fetch_if.sv | 21 ++
 rtl/core_fetch_fifo.sv | 60 ++++++
 rtl/core_fetch.sv | 107 ++++++++++
 tb/tb_core_fetch.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package core_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/core_fetch_if.sv
// Instruction-memory request/response channel between fetch (master) and memory (slave).
interface core_fetch_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/core_fetch_fifo.sv
// Small circular FIFO of fetched instructions; flush has priority over push.
module core_fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; validity is carried entirely by cnt, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/core_fetch.sv
// Fetch stage: owns the PC, issues credit-limited in-order requests, buffers and presents instructions.
module core_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  core_fetch_if.master       imem,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               stall,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               inst_valid,
  output logic               inst_fault
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [31:0]   rsp_pc, rsp_pc_nxt;
  logic [31:0]   last_pc;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] drop_cnt, drop_nxt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          accept, rsp, push, pop, empty;
  fetch_entry_t  head, wentry;

  assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem.req_valid  = (state == RUN) && (credit_used < (CW+1)'(DEPTH));
  assign imem.req_addr   = pc;

  assign accept          = imem.req_valid && imem.req_ready;
  assign rsp             = imem.rsp_valid;
  assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp);

  // rsp_pc tracks the PC of the oldest live request, so responses need no per-request PC storage.
  assign push   = rsp && !redirect && (drop_cnt == '0);
  assign pop    = !empty && !stall;
  assign wentry = '{inst: imem.rsp_data, pc: rsp_pc, fault: imem.rsp_err};

  core_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (redirect),
    .head  (head),
    .count (fifo_count),
    .empty (empty)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    rsp_pc_nxt = rsp_pc;
    drop_nxt   = drop_cnt;

    if (accept)                     pc_nxt     = pc + 32'd4;
    if (push)                       rsp_pc_nxt = rsp_pc + 32'd4;
    if (rsp && (drop_cnt != '0))    drop_nxt   = drop_cnt - CW'(1);

    case (state)
      BOOT:    state_nxt = RUN;
      DRAIN:   if (drop_nxt == '0) state_nxt = RUN;
      default: state_nxt = state;
    endcase

    // In DRAIN every outstanding request is stale, so one formula covers both RUN and DRAIN.
    if (redirect) begin
      pc_nxt     = redirect_pc & ~32'd3;
      rsp_pc_nxt = redirect_pc & ~32'd3;
      drop_nxt   = outstanding_nxt;
      state_nxt  = (outstanding_nxt != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      last_pc     <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_nxt;
      if (!empty) last_pc <= head.pc;
    end
  end

  assign inst_valid = !empty;
  assign inst       = empty ? INST_NOP : head.inst;
  assign inst_pc    = empty ? last_pc  : head.pc;
  assign inst_fault = !empty && head.fault;

endmodule

// File: tb/tb_core_fetch.sv
// Randomized bench for core_fetch: in-order memory model plus an expected-instruction-stream reference.
module tb_core_fetch;
  import core_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_fault;

  core_fetch_if imem ();

  core_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_fault  (inst_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory contents and fault map are pure functions of the address.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic err_fn(input logic [31:0] a);
    return a[6:2] == 5'h08;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          cyc;
  int          pops;
  int          first_valid;
  logic [31:0] exp_req_pc;
  logic [31:0] exp_inst_pc;
  logic        redir_prev, hold_prev, req_hold_prev;
  logic [31:0] held_pc, held_addr;

  int          ready_pct, stall_pct, redir_pct, max_lat;
  logic        force_redir;
  logic [31:0] force_target;

  task automatic model_reset();
    pend.delete();
    exp_req_pc    = RESET_PC;
    exp_inst_pc   = RESET_PC;
    redir_prev    = 1'b0;
    hold_prev     = 1'b0;
    req_hold_prev = 1'b0;
    first_valid   = -1;
    cyc           = 0;
  endtask

  task automatic reset_checks();
    check("rst_req_valid", imem.req_valid, 1'b0);
    check("rst_req_addr",  imem.req_addr, RESET_PC);
    check("rst_inst",      inst, INST_NOP);
    check("rst_inst_pc",   inst_pc, 32'h0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_fault", inst_fault, 1'b0);
  endtask

  // One cycle: called at a negedge; checks outputs, drives inputs for the next posedge, advances the model.
  task automatic step();
    logic        rdy, stl, rdr, acc;
    logic [31:0] tgt;

    if (redir_prev) check("flush_valid", inst_valid, 1'b0);
    if (!inst_valid) begin
      check("empty_inst", inst, INST_NOP);
      check("empty_fault", inst_fault, 1'b0);
    end
    if (hold_prev) begin
      check("stall_hold_valid", inst_valid, 1'b1);
      check("stall_hold_pc", inst_pc, held_pc);
    end
    if (req_hold_prev) begin
      check("req_stable_valid", imem.req_valid, 1'b1);
      check("req_stable_addr", imem.req_addr, held_addr);
    end
    if (inst_valid && first_valid < 0) first_valid = cyc;

    rdy = ($urandom_range(99) < ready_pct);
    stl = ($urandom_range(99) < stall_pct);
    rdr = force_redir || ($urandom_range(99) < redir_pct);
    if (force_redir) tgt = force_target;
    else if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else tgt = 32'($urandom_range(1023));

    imem.req_ready = rdy;
    stall          = stl;
    redirect       = rdr;
    redirect_pc    = tgt;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = $urandom;
    imem.rsp_err   = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem.rsp_valid = 1'b1;
      imem.rsp_data  = mem_data(pend[0].addr);
      imem.rsp_err   = err_fn(pend[0].addr);
      void'(pend.pop_front());
    end

    acc = imem.req_valid && rdy;
    if (acc) begin
      check("req_addr", imem.req_addr, exp_req_pc);
      pend.push_back('{addr: imem.req_addr, due: cyc + 1 + $urandom_range(max_lat)});
      check("credit_limit", (pend.size() <= DEPTH), 1'b1);
    end

    if (inst_valid && !stl) begin
      check("inst_pc", inst_pc, exp_inst_pc);
      check("inst_data", inst, mem_data(exp_inst_pc));
      check("inst_fault", inst_fault, err_fn(exp_inst_pc));
      exp_inst_pc = exp_inst_pc + 32'd4;
      pops++;
    end

    if (rdr) begin
      exp_req_pc  = tgt & ~32'd3;
      exp_inst_pc = tgt & ~32'd3;
    end else if (acc) begin
      exp_req_pc = exp_req_pc + 32'd4;
    end

    redir_prev    = rdr;
    hold_prev     = inst_valid && stl && !rdr;
    held_pc       = inst_pc;
    req_hold_prev = imem.req_valid && !rdy && !rdr;
    held_addr     = imem.req_addr;

    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_knobs(input int rp, input int sp, input int dp, input int ml);
    ready_pct = rp;
    stall_pct = sp;
    redir_pct = dp;
    max_lat   = ml;
  endtask

  task automatic directed_redirect(input logic [31:0] t);
    force_redir  = 1'b1;
    force_target = t;
    step();
    force_redir  = 1'b0;
  endtask

  initial begin
    int  waited;
    logic seen;

    imem.req_ready = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = '0;
    imem.rsp_err   = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    force_redir    = 1'b0;
    force_target   = '0;
    pops           = 0;
    model_reset();

    #12;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    // Boot latency with an always-ready, single-cycle memory.
    set_knobs(100, 0, 0, 0);
    run(12);
    check("boot_latency", 32'(first_valid), 32'd3);

    // Long decode stall: credit limit and head hold.
    set_knobs(100, 100, 0, 0);
    run(5);
    check("stall_req_blocked", imem.req_valid, 1'b0);
    set_knobs(100, 0, 0, 0);
    run(10);

    // Redirect with two requests in flight: stale responses dropped, restart at aligned target.
    set_knobs(100, 100, 0, 3);
    directed_redirect(32'h0000_0010);
    set_knobs(100, 0, 0, 3);
    seen = 1'b0;
    for (waited = 0; waited < 50 && !seen; waited++) begin
      if (pend.size() == 2) seen = 1'b1;
      else step();
    end
    check("two_outstanding", seen, 1'b1);
    directed_redirect(32'h0000_0103);
    seen = 1'b0;
    for (waited = 0; waited < 50 && !seen; waited++) begin
      if (imem.req_valid) seen = 1'b1;
      else step();
    end
    check("redir_req_seen", seen, 1'b1);
    check("redir_req_addr", imem.req_addr, 32'h0000_0100);
    run(20);

    // Address wrap and fault tagging at 0x20.
    directed_redirect(32'hFFFF_FFF8);
    run(20);
    directed_redirect(32'h0000_0018);
    run(20);

    // Mixed random traffic.
    set_knobs(70, 30, 3, 3);
    run(3000);

    // Asynchronous reset mid-run.
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    imem.rsp_valid = 1'b0;
    redirect = 1'b0;
    set_knobs(100, 0, 0, 0);
    run(12);
    check("boot_latency_2", 32'(first_valid), 32'd3);
    set_knobs(60, 25, 4, 4);
    run(1000);

    check("progress", (pops > 500), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
